// File: rtl/wb_master_nop_pkg.sv
// Shared types for the no-data Wishbone B4 classic master.
package wb_master_nop_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_GAP    = 2'd2
    } state_t;

    localparam int WB_CYC_W = 1;
    localparam int WB_STB_W = 1;
    localparam int WB_ACK_W = 1;

endpackage

// File: rtl/wb_nop_watchdog.sv
// Saturating wait-state counter; flags expiry once LIMIT ackless edges elapse.
module wb_nop_watchdog #(
    parameter int unsigned LIMIT = 1,
    parameter int unsigned CNT_W = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);
    localparam logic [CNT_W-1:0] MAX  = '1;

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt <= '0;
        end else if (clr_i) begin
            r_cnt <= '0;
        end else if (en_i && (r_cnt != MAX)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Count holds the ackless edges already seen; this edge is the LIMIT-th.
    assign expired_o = (r_cnt >= LAST);

endmodule

// File: rtl/wb_master_nop.sv
// Wishbone B4 classic master issuing one CYC/STB-only cycle per trigger.
module wb_master_nop
    import wb_master_nop_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 0,
    parameter int unsigned CNT_W          = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    output logic cyc_o,
    output logic stb_o,
    input  logic ack_i,
    input  logic trigger_i,
    output logic busy_o,
    output logic done_o,
    output logic timeout_o
);

    state_t r_state;
    logic   r_cyc;
    logic   r_done;
    logic   r_tmo;
    logic   w_expired;

    generate
        if (TIMEOUT_CYCLES > 0) begin : g_wd
            logic w_clr;
            logic w_en;

            assign w_clr = (r_state == ST_IDLE) && trigger_i;
            assign w_en  = (r_state == ST_ACTIVE) && !ack_i;

            wb_nop_watchdog #(
                .LIMIT (TIMEOUT_CYCLES),
                .CNT_W (CNT_W)
            ) u_wd (
                .clk_i     (clk_i),
                .rst_i     (rst_i),
                .clr_i     (w_clr),
                .en_i      (w_en),
                .expired_o (w_expired)
            );
        end else begin : g_nowd
            assign w_expired = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_cyc   <= 1'b0;
            r_done  <= 1'b0;
            r_tmo   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_tmo  <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (trigger_i) begin
                        r_state <= ST_ACTIVE;
                        r_cyc   <= 1'b1;
                    end
                end
                ST_ACTIVE: begin
                    // Ack takes priority over a simultaneous watchdog expiry.
                    if (ack_i) begin
                        r_state <= ST_GAP;
                        r_cyc   <= 1'b0;
                        r_done  <= 1'b1;
                    end else if (w_expired) begin
                        r_state <= ST_GAP;
                        r_cyc   <= 1'b0;
                        r_tmo   <= 1'b1;
                    end
                end
                ST_GAP: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cyc   <= 1'b0;
                end
            endcase
        end
    end

    assign cyc_o     = r_cyc;
    assign stb_o     = r_cyc;
    assign busy_o    = r_cyc;
    assign done_o    = r_done;
    assign timeout_o = r_tmo;

endmodule

// File: tb/tb_wb_master_nop.sv
// Randomised scoreboard bench for wb_master_nop with and without the watchdog.
module tb_wb_master_nop;

    logic clk = 1'b0;
    logic rst;
    logic trig;
    logic ack;

    logic cyc0, stb0, busy0, done0, tmo0;
    logic cyc4, stb4, busy4, done4, tmo4;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    wb_master_nop #(.TIMEOUT_CYCLES(0), .CNT_W(16)) u_dut0 (
        .clk_i     (clk),
        .rst_i     (rst),
        .cyc_o     (cyc0),
        .stb_o     (stb0),
        .ack_i     (ack),
        .trigger_i (trig),
        .busy_o    (busy0),
        .done_o    (done0),
        .timeout_o (tmo0)
    );

    wb_master_nop #(.TIMEOUT_CYCLES(4), .CNT_W(16)) u_dut4 (
        .clk_i     (clk),
        .rst_i     (rst),
        .cyc_o     (cyc4),
        .stb_o     (stb4),
        .ack_i     (ack),
        .trigger_i (trig),
        .busy_o    (busy4),
        .done_o    (done4),
        .timeout_o (tmo4)
    );

    // Reference: a cycle in flight, how long it has waited, and a pending gap.
    int unsigned tmo_lim [2] = '{0, 4};
    bit          m_in    [2];
    int          m_wait  [2];
    bit          m_gap   [2];

    logic [4:0] q0[$];
    logic [4:0] q4[$];

    task automatic chk(input string name, input logic [4:0] act,
                       input logic [4:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (cyc,stb,busy,done,tmo) t=%0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_in[k]   = 1'b0;
            m_wait[k] = 0;
            m_gap[k]  = 1'b0;
        end
        q0.delete();
        q4.delete();
    endtask

    function automatic logic [4:0] model_edge(input int k, input bit t,
                                              input bit a);
        bit dn, to;
        dn = 1'b0;
        to = 1'b0;
        if (m_in[k]) begin
            if (a) begin
                m_in[k]  = 1'b0;
                m_gap[k] = 1'b1;
                dn       = 1'b1;
            end else begin
                m_wait[k]++;
                if (tmo_lim[k] > 0 && m_wait[k] >= int'(tmo_lim[k])) begin
                    m_in[k]  = 1'b0;
                    m_gap[k] = 1'b1;
                    to       = 1'b1;
                end
            end
        end else if (m_gap[k]) begin
            m_gap[k] = 1'b0;
        end else if (t) begin
            m_in[k]   = 1'b1;
            m_wait[k] = 0;
        end
        return {m_in[k], m_in[k], m_in[k], dn, to};
    endfunction

    task automatic step(input bit t, input bit a);
        bit tt, aa;
        @(negedge clk);
        trig = t;
        ack  = a;
        tt   = t;
        aa   = a;
        @(posedge clk);
        q0.push_back(model_edge(0, tt, aa));
        q4.push_back(model_edge(1, tt, aa));
    endtask

    // Monitor: compares each post-edge DUT output against the queued prediction.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!rst) begin
                if (q0.size() > 0)
                    chk("dut0_out", {cyc0, stb0, busy0, done0, tmo0},
                        q0.pop_front());
                if (q4.size() > 0)
                    chk("dut4_out", {cyc4, stb4, busy4, done4, tmo4},
                        q4.pop_front());
            end
        end
    end

    initial begin
        rst  = 1'b1;
        trig = 1'b0;
        ack  = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset0", {cyc0, stb0, busy0, done0, tmo0}, 5'b0);
        chk("reset4", {cyc4, stb4, busy4, done4, tmo4}, 5'b0);
        @(negedge clk);
        rst = 1'b0;

        // Stray ack while idle
        repeat (4) step(1'b0, 1'b1);

        // Basic cycle
        step(1'b1, 1'b0);
        repeat (3) step(1'b0, 1'b1);
        repeat (2) step(1'b0, 1'b0);

        // Wait states: ack after 5 low cycles
        step(1'b1, 1'b0);
        repeat (5) step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        repeat (3) step(1'b0, 1'b0);

        // Held trigger with permanent ack
        repeat (12) step(1'b1, 1'b1);
        repeat (3) step(1'b0, 1'b0);

        // Watchdog expiry
        step(1'b1, 1'b0);
        repeat (8) step(1'b0, 1'b0);

        // Ack on the exact expiry edge
        step(1'b1, 1'b0);
        repeat (3) step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        repeat (3) step(1'b0, 1'b0);

        // Asynchronous reset in the middle of a cycle
        step(1'b1, 1'b0);
        @(negedge clk);
        trig = 1'b0;
        chk("pre_rst", {cyc0, stb0, busy0, cyc4, stb4}, 5'b11111);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst", {cyc0, stb0, busy0, cyc4, stb4}, 5'b0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) step(1'b0, 1'b0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom % 3) == 0, ($urandom % 5) == 0);
        end
        step(1'b0, 1'b0);

        @(posedge clk);
        #3;
        if (q0.size() != 0 || q4.size() != 0) begin
            errors++;
            checks++;
            $display("FAIL drain: got %0d/%0d queued expected 0/0",
                     q0.size(), q4.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
